// File: rtl/apb_arb_pkg.sv
// Shared types and default parameters for the two-port APB master arbiter.
package apb_arb_pkg;

    // Bus phase encoding of the master FSM
    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        SETUP  = 2'b01,
        ACCESS = 2'b10
    } arb_state_t;

    localparam int DEF_ADDR_W  = 8;
    localparam int DEF_DATA_W  = 8;
    localparam int DEF_TIMEOUT = 15;

endpackage

// File: rtl/apb_rr_arb.sv
// Two-way round-robin grant. The pointer remembers the requester that
// completed last, so on contention the other one wins.
module apb_rr_arb (
    input  logic       PCLK,
    input  logic       PRESET,
    input  logic [1:0] eligible,
    input  logic       cpl_strobe,
    input  logic       cpl_idx,
    output logic       grant_valid,
    output logic       grant_idx
);

    logic last_reg;
    logic last_next;

    // Grant selection from the eligible vector and the last-served pointer
    always_comb begin
        grant_valid = |eligible;
        grant_idx   = 1'b0;
        case (eligible)
            2'b10:   grant_idx = 1'b1;
            2'b11:   grant_idx = ~last_reg;
            default: grant_idx = 1'b0;
        endcase
        last_next = cpl_strobe ? cpl_idx : last_reg;
    end

    // Pointer register; after reset requester 0 wins the first contention
    always_ff @(posedge PCLK) begin
        if (!PRESET) begin
            last_reg <= 1'b1;
        end else begin
            last_reg <= last_next;
        end
    end

endmodule

// File: rtl/apb_master_arbiter.sv
// Two-port APB master: round-robin between two local requesters, runs the
// IDLE/SETUP/ACCESS sequence, honours PREADY and aborts stalled accesses.
module apb_master_arbiter
    import apb_arb_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                PCLK,
    input  logic                PRESET,
    input  logic [1:0]          req,
    input  logic [1:0]          we,
    input  logic [2*ADDR_W-1:0] addr,
    input  logic [2*DATA_W-1:0] wdata,
    output logic [1:0]          done,
    output logic [1:0]          err,
    output logic [DATA_W-1:0]   rdata,
    output logic                PSEL,
    output logic                PENABLE,
    output logic                PWRITE,
    output logic [ADDR_W-1:0]   PADDR,
    output logic [DATA_W-1:0]   PWDATA,
    input  logic [DATA_W-1:0]   PRDATA,
    input  logic                PREADY
);

    // Wait counter value on the last allowed stalled ACCESS cycle
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    arb_state_t        state_reg, state_next;
    logic              grant_reg, grant_next;
    logic [7:0]        cnt_reg, cnt_next;
    logic [1:0]        done_reg, done_next;
    logic [1:0]        err_reg, err_next;
    logic [DATA_W-1:0] rdata_reg, rdata_next;
    logic              pwrite_reg, pwrite_next;
    logic [ADDR_W-1:0] paddr_reg, paddr_next;
    logic [DATA_W-1:0] pwdata_reg, pwdata_next;

    logic              arb_valid;
    logic              arb_grant;
    logic              cpl_strobe;
    logic [1:0]        eligible;

    logic [ADDR_W-1:0] addr_arr  [2];
    logic [DATA_W-1:0] wdata_arr [2];

    // Split the flat requester buses into per-requester fields
    for (genvar gi = 0; gi < 2; gi++) begin : g_split
        assign addr_arr[gi]  = addr[gi*ADDR_W +: ADDR_W];
        assign wdata_arr[gi] = wdata[gi*DATA_W +: DATA_W];
    end

    // A requester is masked during its own done cycle only
    assign eligible = req & ~done_reg;

    apb_rr_arb u_arb (
        .PCLK        (PCLK),
        .PRESET      (PRESET),
        .eligible    (eligible),
        .cpl_strobe  (cpl_strobe),
        .cpl_idx     (grant_reg),
        .grant_valid (arb_valid),
        .grant_idx   (arb_grant)
    );

    // Next-state and datapath logic; address/data/direction hold unless granting
    always_comb begin
        state_next  = state_reg;
        grant_next  = grant_reg;
        cnt_next    = cnt_reg;
        done_next   = 2'b00;
        err_next    = 2'b00;
        rdata_next  = '0;
        pwrite_next = pwrite_reg;
        paddr_next  = paddr_reg;
        pwdata_next = pwdata_reg;
        cpl_strobe  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (arb_valid) begin
                    grant_next  = arb_grant;
                    pwrite_next = we[arb_grant];
                    paddr_next  = addr_arr[arb_grant];
                    pwdata_next = wdata_arr[arb_grant];
                    state_next  = SETUP;
                end
            end
            SETUP: begin
                cnt_next   = '0;
                state_next = ACCESS;
            end
            ACCESS: begin
                // PREADY wins even on the final allowed cycle
                if (PREADY) begin
                    rdata_next            = pwrite_reg ? '0 : PRDATA;
                    done_next[grant_reg]  = 1'b1;
                    cpl_strobe            = 1'b1;
                    state_next            = IDLE;
                end else if (cnt_reg == TO_LAST) begin
                    done_next[grant_reg]  = 1'b1;
                    err_next[grant_reg]   = 1'b1;
                    cpl_strobe            = 1'b1;
                    state_next            = IDLE;
                end else begin
                    cnt_next = cnt_reg + 8'd1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State and output registers
    always_ff @(posedge PCLK) begin
        if (!PRESET) begin
            state_reg  <= IDLE;
            grant_reg  <= 1'b0;
            cnt_reg    <= '0;
            done_reg   <= 2'b00;
            err_reg    <= 2'b00;
            rdata_reg  <= '0;
            pwrite_reg <= 1'b0;
            paddr_reg  <= '0;
            pwdata_reg <= '0;
        end else begin
            state_reg  <= state_next;
            grant_reg  <= grant_next;
            cnt_reg    <= cnt_next;
            done_reg   <= done_next;
            err_reg    <= err_next;
            rdata_reg  <= rdata_next;
            pwrite_reg <= pwrite_next;
            paddr_reg  <= paddr_next;
            pwdata_reg <= pwdata_next;
        end
    end

    assign PSEL    = (state_reg != IDLE);
    assign PENABLE = (state_reg == ACCESS);
    assign PWRITE  = pwrite_reg;
    assign PADDR   = paddr_reg;
    assign PWDATA  = pwdata_reg;
    assign done    = done_reg;
    assign err     = err_reg;
    assign rdata   = rdata_reg;

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Self-checking bench for apb_master_arbiter (TIMEOUT=4) with a small APB
// slave memory, a transaction table and a scoreboard of expected completions.
module tb_apb_master_arbiter;

    localparam int AW = 8;
    localparam int DW = 8;
    localparam int TO = 4;

    logic          PCLK;
    logic          PRESET;
    logic [1:0]    req;
    logic [1:0]    we;
    logic [2*AW-1:0] addr;
    logic [2*DW-1:0] wdata;
    logic [1:0]    done;
    logic [1:0]    err;
    logic [DW-1:0] rdata;
    logic          PSEL;
    logic          PENABLE;
    logic          PWRITE;
    logic [AW-1:0] PADDR;
    logic [DW-1:0] PWDATA;
    logic [DW-1:0] PRDATA;
    logic          PREADY;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] mem [256];

    typedef struct {
        logic       idx;
        logic       w;
        logic [7:0] a;
        logic [7:0] d;
        int         waits;
        logic       drop;
        logic       exp_err;
        logic [7:0] exp_rdata;
        int         exp_lat;
    } vec_t;

    typedef struct {
        logic       idx;
        logic       err;
        logic [7:0] rdata;
        int         lat;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[10];

    apb_master_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .PCLK    (PCLK),
        .PRESET  (PRESET),
        .req     (req),
        .we      (we),
        .addr    (addr),
        .wdata   (wdata),
        .done    (done),
        .err     (err),
        .rdata   (rdata),
        .PSEL    (PSEL),
        .PENABLE (PENABLE),
        .PWRITE  (PWRITE),
        .PADDR   (PADDR),
        .PWDATA  (PWDATA),
        .PRDATA  (PRDATA),
        .PREADY  (PREADY)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        PRESET = 1'b0;
        req = 2'b00;
        PREADY = 1'b0;
        repeat (2) @(posedge PCLK);
        #1;
        PRESET = 1'b1;
    endtask

    task automatic run_txn(input int n, input vec_t v);
        exp_t e;
        int   acc;
        bit   bus_ok;
        bit   got;
        int   lat;
        req[v.idx] = 1'b1;
        we[v.idx]  = v.w;
        addr[v.idx*AW +: AW]  = v.a;
        wdata[v.idx*DW +: DW] = v.d;
        sb.push_back('{idx: v.idx, err: v.exp_err, rdata: v.exp_rdata, lat: v.exp_lat});
        acc = 0;
        bus_ok = 1'b1;
        got = 1'b0;
        lat = 0;
        for (int c = 1; c <= 40 && !got; c++) begin
            @(posedge PCLK);
            #1;
            PREADY = 1'b0;
            if (c == 1) begin
                check("setup_phase", 32'({PSEL, PENABLE}), 32'(2'b10));
                if (v.drop) req[v.idx] = 1'b0;
            end
            if (PSEL && (PADDR !== v.a || PWRITE !== v.w || (v.w && PWDATA !== v.d)))
                bus_ok = 1'b0;
            if (PSEL && PENABLE) begin
                PRDATA = mem[PADDR];
                PREADY = (acc == v.waits);
                if (PREADY && PWRITE) mem[PADDR] = PWDATA;
                acc++;
            end
            if (done != 2'b00) begin
                got = 1'b1;
                lat = c;
                if (sb.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL scoreboard: got done=%b, want no completion", done);
                end else begin
                    e = sb.pop_front();
                    check("done_bits", 32'(done), e.idx ? 32'(2'b10) : 32'(2'b01));
                    check("err_bits", 32'(err), e.err ? (e.idx ? 32'(2'b10) : 32'(2'b01)) : 32'(0));
                    check("rdata", 32'(rdata), 32'(e.rdata));
                    check("latency", 32'(c), 32'(e.lat));
                    check("bus_stable", 32'(bus_ok), 32'(1));
                    check("psel_after_done", 32'(PSEL), 32'(0));
                end
                $display("txn %0d req%0d we=%0d addr=%02h done=%b err=%b rdata=%02h lat=%0d",
                         n, v.idx, v.w, v.a, done, err, rdata, lat);
                req[v.idx] = 1'b0;
            end
        end
        if (!got) begin
            n_checks++;
            n_errors++;
            $display("FAIL done_timeout: got no done in 40 cycles, want done for txn %0d", n);
            void'(sb.pop_front());
        end
        @(posedge PCLK);
        #1;
        check("done_single", 32'(done), 32'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, want finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        PRESET = 1'b0;
        req    = 2'b00;
        we     = 2'b00;
        addr   = '0;
        wdata  = '0;
        PRDATA = '0;
        PREADY = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;

        //        idx  w     a      d      waits drop  err   rdata  lat
        vecs[0] = '{1'b0, 1'b1, 8'h05, 8'hA5, 0, 1'b0, 1'b0, 8'h00, 3};
        vecs[1] = '{1'b0, 1'b0, 8'h05, 8'h00, 0, 1'b0, 1'b0, 8'hA5, 3};
        vecs[2] = '{1'b1, 1'b1, 8'h3C, 8'h5A, 3, 1'b0, 1'b0, 8'h00, 6};
        vecs[3] = '{1'b1, 1'b0, 8'h3C, 8'h00, 1, 1'b0, 1'b0, 8'h5A, 4};
        vecs[4] = '{1'b1, 1'b0, 8'h05, 8'h00, 9, 1'b0, 1'b1, 8'h00, 6};
        vecs[5] = '{1'b0, 1'b0, 8'h3C, 8'h00, 3, 1'b0, 1'b0, 8'h5A, 6};
        vecs[6] = '{1'b1, 1'b1, 8'hFF, 8'h81, 2, 1'b1, 1'b0, 8'h00, 5};
        vecs[7] = '{1'b0, 1'b0, 8'hFF, 8'h00, 0, 1'b0, 1'b0, 8'h81, 3};
        vecs[8] = '{1'b0, 1'b1, 8'h3C, 8'hC3, 9, 1'b0, 1'b1, 8'h00, 6};
        vecs[9] = '{1'b1, 1'b0, 8'h3C, 8'h00, 0, 1'b0, 1'b0, 8'h5A, 3};

        // Reset state
        do_reset();
        check("rst_psel_penable", 32'({PSEL, PENABLE}), 32'(0));
        check("rst_pwrite", 32'(PWRITE), 32'(0));
        check("rst_paddr", 32'(PADDR), 32'(0));
        check("rst_pwdata", 32'(PWDATA), 32'(0));
        check("rst_done_err", 32'({done, err}), 32'(0));
        check("rst_rdata", 32'(rdata), 32'(0));

        // Contention from reset: 0, 1, 0 with one IDLE cycle between transfers
        req    = 2'b11;
        we     = 2'b00;
        addr   = {8'h42, 8'h21};
        PREADY = 1'b1;
        for (int c = 1; c <= 9; c++) begin
            int ph;
            int k;
            logic [11:0] exp_v;
            @(posedge PCLK);
            #1;
            ph = (c - 1) % 3;
            k  = (c - 1) / 3;
            exp_v = {(ph != 2), (ph == 1),
                     (ph == 2) ? ((k % 2) != 0 ? 2'b10 : 2'b01) : 2'b00,
                     (k % 2) != 0 ? 8'h42 : 8'h21};
            check("contention", 32'({PSEL, PENABLE, done, PADDR}), 32'(exp_v));
            $display("contention cycle %0d psel=%0d penable=%0d done=%b paddr=%02h",
                     c, PSEL, PENABLE, done, PADDR);
        end
        req    = 2'b00;
        PREADY = 1'b0;

        // Table-driven single transfers
        do_reset();
        for (int i = 0; i < 10; i++) run_txn(i, vecs[i]);

        // Reset in the middle of a stalled ACCESS
        req   = 2'b10;
        we    = 2'b10;
        addr  = {8'h77, 8'h11};
        wdata = {8'h99, 8'h00};
        for (int c = 1; c <= 3; c++) begin
            @(posedge PCLK);
            #1;
            PREADY = 1'b0;
        end
        check("pre_reset_access", 32'({PSEL, PENABLE, PADDR}), 32'({2'b11, 8'h77}));
        PRESET = 1'b0;
        @(posedge PCLK);
        #1;
        check("midrst_bus", 32'({PSEL, PENABLE, PWRITE, PADDR}), 32'(0));
        check("midrst_done_err", 32'({done, err}), 32'(0));
        PRESET = 1'b1;
        req    = 2'b11;
        we     = 2'b00;
        @(posedge PCLK);
        #1;
        check("post_rst_grant0", 32'({PSEL, PENABLE, PADDR, done}), 32'({2'b10, 8'h11, 2'b00}));
        @(posedge PCLK);
        #1;
        check("post_rst_access", 32'({PSEL, PENABLE, done, err}), 32'({2'b11, 4'b0000}));
        PRDATA = mem[PADDR];
        PREADY = 1'b1;
        @(posedge PCLK);
        #1;
        PREADY = 1'b0;
        check("post_rst_done", 32'({done, err}), 32'({2'b01, 2'b00}));
        $display("reset-abort sequence done=%b err=%b paddr=%02h", done, err, PADDR);
        req = 2'b00;
        repeat (2) @(posedge PCLK);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/apb_master_arbiter.md
# apb_master_arbiter

Two-port APB master that shares one APB slave bus (the 8-bit AMBA_APB memory slave) between two local requesters. It arbitrates round-robin, sequences the IDLE/SETUP/ACCESS phases, honours PREADY wait states and aborts stalled transfers after a programmable timeout. It sits between the bus-bridge side logic and the APB slave.

## Interface
- ADDR_W, 8, PADDR / request address width
- DATA_W, 8, PWDATA/PRDATA/request data width
- TIMEOUT, 15, maximum ACCESS cycles with PREADY=0 before abort (legal 1..255)
- PCLK  in  1  clock; all logic on rising edge
- PRESET  in  1  reset, synchronous, active-low
- req  in  2  per-requester request; held with its command until its done pulse
- we  in  2  per-requester write(1)/read(0)
- addr  in  2*ADDR_W  requester i at [i*ADDR_W +: ADDR_W]
- wdata  in  2*DATA_W  requester i at [i*DATA_W +: DATA_W]
- done  out  2  one-cycle completion pulse per requester
- err  out  2  one-cycle timeout flag, coincident with done
- rdata  out  DATA_W  read data, valid only while a done bit is high
- PSEL, PENABLE, PWRITE  out  1  APB master controls
- PADDR  out  ADDR_W; PWDATA  out  DATA_W
- PRDATA  in  DATA_W; PREADY  in  1

## Operation
- FSM: IDLE, SETUP, ACCESS.
- IDLE: eligible = req & ~done. None eligible -> stay. One eligible -> grant it. Both -> grant the requester not granted last; round-robin pointer resets to "last = 1", so requester 0 wins the first contention.
- On grant: register g, PWRITE=we[g], PADDR=addr[g], PWDATA=wdata[g]; -> SETUP.
- SETUP: PSEL=1, PENABLE=0, exactly one cycle; -> ACCESS, clear wait counter.
- ACCESS: PSEL=1, PENABLE=1. PREADY=1 -> capture PRDATA into rdata (reads; 0 for writes), pulse done[g] next cycle, update pointer, -> IDLE. PREADY=0 -> increment counter; on reaching TIMEOUT -> pulse done[g] and err[g], rdata=0, -> IDLE.
- PADDR/PWRITE/PWDATA held stable from SETUP through end of ACCESS; retain last values in IDLE.
- Requester dropping req mid-transfer: transfer still completes, done still pulses.
- Requester keeping req high after done: treated as a new request; masked only during the done cycle.

## Timing
- Reset (PRESET=0 at an edge): next cycle PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, done=0, err=0, rdata=0, state IDLE, counter 0, pointer=1. Mid-transfer reset aborts with no done pulse.
- Zero-wait latency: req high in cycle 0 -> SETUP cycle 1 -> ACCESS cycle 2 (PREADY=1) -> done cycle 3 (IDLE). N wait states add N cycles.
- Minimum one IDLE cycle between consecutive transfers; the other requester may be granted in that cycle.
- Timeout: done/err asserted the cycle after the TIMEOUT-th consecutive PREADY=0 ACCESS cycle; PREADY arriving in that same final cycle counts as success (PREADY has priority).
- done, err, rdata are registered; never asserted for more than one cycle per transfer.

## Structure
- Package apb_arb_pkg: state encoding IDLE=2'b00, SETUP=2'b01, ACCESS=2'b10; default ADDR_W/DATA_W/TIMEOUT constants.
- Sub-module apb_rr_arb: 2-way round-robin grant from eligible vector and pointer, pointer updated on completion strobe. FSM, counter and datapath stay in top.

## Test plan
- Single write then read: req0 we=1 addr=8'h05 wdata=8'hA5, PREADY=1 -> PSEL cycle 1, PENABLE cycle 2, done[0] cycle 3; read addr 8'h05 -> rdata=8'hA5 with done[0].
- Contention: req=2'b11 from reset -> requester 0 first, then 1, then 0; PADDR alternates, one IDLE cycle between transfers.
- Wait states: PREADY low 3 ACCESS cycles -> done 6 cycles after req, PADDR/PWDATA stable throughout.
- Timeout: TIMEOUT=4, PREADY held 0 -> done[1]=err[1]=1 after 4 ACCESS cycles, rdata=0, PSEL low next cycle; PREADY on 4th cycle -> err=0.
- Reset mid-ACCESS: PRESET=0 during wait -> PSEL/PENABLE=0, no done/err, next transfer after release grants requester 0 first.
